// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by pc[IDX_W+1:2].
// The FD stage looks the table up combinationally; unresolved FD branches carry
// their prediction and index into X, where the resolution trains the counter.
// Optional build macro BP_STATS_EN adds branch / mispredict statistics counters.
module branch_predictor #(
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_fd,
  input  logic        fd_is_branch,
  input  logic        fd_br_resolved,
  input  logic        fd_br_taken,
  input  logic        flush,
  input  logic        x_br_resolve,
  input  logic        x_br_taken,
  output logic        pred_taken_fd,
  output logic        pred_taken_x,
  output logic        x_pred_valid
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  // Saturating counter step: taken moves toward 3, not-taken toward 0.
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == 2'd3) ? 2'd3 : c + 2'd1;
    end
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  logic [1:0]       cnt_q [BHT_ENTRIES];
  logic [1:0]       cnt_d [BHT_ENTRIES];
  logic [IDX_W-1:0] idx_x_q, idx_x_d;
  logic             x_pred_valid_q, x_pred_valid_d;
  logic             pred_taken_x_q, pred_taken_x_d;

  logic [IDX_W-1:0] idx_fd;
  logic             lookup_carry;
  logic             x_upd;
  logic             fd_upd;
  logic [1:0]       x_new;
  logic [1:0]       fd_base;
  logic [1:0]       fd_new;

  // PC bits outside the index field do not participate in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_fd[31:IDX_W+2], pc_fd[1:0]};

  // Lookup and update qualifiers.
  always_comb begin
    idx_fd        = pc_fd[IDX_W+1:2];
    pred_taken_fd = cnt_q[idx_fd][1] & fd_is_branch;
    lookup_carry  = fd_is_branch & ~fd_br_resolved & ~flush;
    x_upd         = x_br_resolve & x_pred_valid_q;
    fd_upd        = fd_is_branch & fd_br_resolved & ~flush;
  end

  // Next table state: X update first, FD update chained on top when indices collide.
  always_comb begin
    cnt_d   = cnt_q;
    x_new   = sat_step(cnt_q[idx_x_q], x_br_taken);
    fd_base = (x_upd && (idx_x_q == idx_fd)) ? x_new : cnt_q[idx_fd];
    fd_new  = sat_step(fd_base, fd_br_taken);
    if (x_upd) begin
      cnt_d[idx_x_q] = x_new;
    end
    if (fd_upd) begin
      cnt_d[idx_fd] = fd_new;
    end
  end

  // Next X-stage payload: only branches left unresolved in FD travel with a prediction.
  always_comb begin
    x_pred_valid_d = lookup_carry;
    pred_taken_x_d = lookup_carry & pred_taken_fd;
    idx_x_d        = idx_fd;
  end

  // Counter table and X-stage registers; reset drops any pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '{default: 2'd1};
      idx_x_q        <= '0;
      x_pred_valid_q <= 1'b0;
      pred_taken_x_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_x_q        <= idx_x_d;
      x_pred_valid_q <= x_pred_valid_d;
      pred_taken_x_q <= pred_taken_x_d;
    end
  end

  assign x_pred_valid = x_pred_valid_q;
  assign pred_taken_x = pred_taken_x_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Statistics: one count per applied update, mispredicts only from X resolutions.
  always_comb begin
    stat_branches_d    = stat_branches_q + 32'(x_upd) + 32'(fd_upd);
    stat_mispredicts_d = stat_mispredicts_q + 32'(x_upd & (x_br_taken != pred_taken_x_q));
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (BHT_ENTRIES=64, index = pc[7:2]).
// Stimulus pushes hand-computed expectations per cycle; a negedge monitor checks them.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_fd;
  logic        fd_is_branch, fd_br_resolved, fd_br_taken, flush;
  logic        x_br_resolve, x_br_taken;
  logic        pred_taken_fd, pred_taken_x, x_pred_valid;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        fd;
    logic        xv;
    logic        px;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  exp_t exp_q[$];

  branch_predictor #(.BHT_ENTRIES(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_fd         (pc_fd),
    .fd_is_branch  (fd_is_branch),
    .fd_br_resolved(fd_br_resolved),
    .fd_br_taken   (fd_br_taken),
    .flush         (flush),
    .x_br_resolve  (x_br_resolve),
    .x_br_taken    (x_br_taken),
    .pred_taken_fd (pred_taken_fd),
    .pred_taken_x  (pred_taken_x),
    .x_pred_valid  (x_pred_valid)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare the DUT outputs presented in this cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".pred_taken_fd"}, 32'(pred_taken_fd), 32'(e.fd));
      chk({e.name, ".x_pred_valid"},  32'(x_pred_valid),  32'(e.xv));
      chk({e.name, ".pred_taken_x"},  32'(pred_taken_x),  32'(e.px));
`ifdef BP_STATS_EN
      chk({e.name, ".stat_branches"},    stat_branches,    e.br);
      chk({e.name, ".stat_mispredicts"}, stat_mispredicts, e.mis);
`endif
    end
  end

  // One cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input string name, input logic [31:0] pc, input logic isb, input logic res,
                     input logic fdt, input logic fl, input logic xr, input logic xt,
                     input logic e_fd, input logic e_xv, input logic e_px,
                     input int e_br, input int e_mis);
    exp_t e;
    @(posedge clk);
    #1;
    pc_fd = pc; fd_is_branch = isb; fd_br_resolved = res; fd_br_taken = fdt;
    flush = fl; x_br_resolve = xr; x_br_taken = xt;
    e.name = name; e.fd = e_fd; e.xv = e_xv; e.px = e_px;
    e.br = 32'(e_br); e.mis = 32'(e_mis);
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pc_fd = '0; fd_is_branch = 0; fd_br_resolved = 0; fd_br_taken = 0;
    flush = 0; x_br_resolve = 0; x_br_taken = 0;
    //   name          pc         isb res fdt fl xr xt  fd xv px  br mis
    cyc("in_reset",    32'h100,   1,  0,  0,  0, 1, 1,  0, 0, 0,  0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back('{name: "reset_idle", fd: 1'b0, xv: 1'b0, px: 1'b0, br: 32'd0, mis: 32'd0});
    cyc("lookup_100",  32'h100,   1,  0,  0,  0, 0, 0,  0, 1, 0,  0, 0);
    cyc("xtrain1",     32'h100,   1,  0,  0,  0, 1, 1,  0, 1, 0,  0, 0);
    cyc("xtrain2",     32'h100,   1,  0,  0,  0, 1, 1,  1, 1, 0,  1, 1);
    cyc("xtrain3",     32'h100,   1,  0,  0,  0, 1, 1,  1, 1, 1,  2, 2);
    cyc("xtrain4",     32'h100,   1,  0,  0,  0, 1, 1,  1, 1, 1,  3, 2);
    cyc("flush_200",   32'h200,   1,  0,  0,  1, 0, 0,  1, 1, 1,  4, 2);
    cyc("ign_resolve", 32'h200,   0,  0,  0,  0, 1, 0,  0, 0, 0,  4, 2);
    cyc("fd_nt_300",   32'h300,   1,  1,  0,  0, 0, 0,  1, 0, 0,  4, 2);
    cyc("look_300",    32'h300,   1,  0,  0,  0, 0, 0,  1, 0, 0,  5, 2);
    cyc("dual_same",   32'h300,   1,  1,  0,  0, 1, 1,  1, 1, 1,  5, 2);
    cyc("after_dual",  32'h300,   1,  1,  1,  0, 0, 0,  1, 0, 0,  7, 2);
    cyc("fd_nt_300b",  32'h300,   1,  1,  0,  0, 0, 0,  1, 0, 0,  8, 2);
    cyc("look_300b",   32'h300,   1,  0,  0,  0, 0, 0,  1, 0, 0,  9, 2);
    cyc("dual_diff",   32'h104,   1,  1,  1,  0, 1, 0,  0, 1, 1,  9, 2);
    cyc("fd_t_104",    32'h104,   1,  1,  1,  0, 0, 0,  1, 0, 0, 11, 3);
    cyc("alias_204",   32'h204,   1,  0,  0,  0, 0, 0,  1, 0, 0, 12, 3);
    cyc("look_100",    32'h100,   1,  0,  0,  0, 0, 0,  0, 1, 1, 12, 3);
    cyc("sat_zero",    32'h100,   1,  1,  0,  0, 1, 0,  0, 1, 0, 12, 3);
    cyc("from_zero",   32'h100,   1,  1,  1,  0, 0, 0,  0, 0, 0, 14, 3);
    cyc("look_100b",   32'h100,   1,  0,  0,  0, 0, 0,  0, 0, 0, 15, 3);
    cyc("pending_upd", 32'h104,   1,  1,  0,  0, 1, 1,  1, 1, 0, 15, 3);
    @(negedge clk); #1 rst_n = 1'b0;
    cyc("mid_reset",   32'h104,   1,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    pc_fd = 32'h104; fd_is_branch = 1; fd_br_resolved = 0; fd_br_taken = 0;
    flush = 0; x_br_resolve = 0; x_br_taken = 0;
    exp_q.push_back('{name: "post_reset", fd: 1'b0, xv: 1'b0, px: 1'b0, br: 32'd0, mis: 32'd0});
    cyc("post_reset2", 32'h100,   0,  0,  0,  0, 0, 0,  0, 1, 0,  0, 0);
    cyc("look_104",    32'h104,   1,  0,  0,  0, 0, 0,  0, 0, 0,  0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
